// File: rtl/osc_meter_pkg.sv
// osc_meter_pkg: shared state encoding and default widths for the oscillator frequency meter
package osc_meter_pkg;
  localparam int CNT_W_DEF  = 16;
  localparam int WIN_W_DEF  = 16;
  localparam int SETTLE_DEF = 8;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DONE} state_e;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus history flop, pulses rise for one clk per rising edge
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise
);
  logic s1_q, s2_q, h_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1_q, s2_q, h_q} <= '0;
    else        {s1_q, s2_q, h_q} <= {d_async, s1_q, s2_q};
  assign rise = s2_q & ~h_q;
endmodule

// File: rtl/osc_freq_meter.sv
// osc_freq_meter: enables an oscillator, lets it settle, then counts its rising edges over a
// programmable number of clk cycles and reports a saturating count with a one-cycle valid pulse.
module osc_freq_meter import osc_meter_pkg::*; #(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WIN_W  = WIN_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             overflow
);
  localparam logic [WIN_W-1:0] SET_LD = WIN_W'(SETTLE - 1);
  state_e           state_q;
  logic [WIN_W-1:0] win_q, tmr_q;
  logic [CNT_W-1:0] count_q;
  logic             osc_en_q, busy_q, valid_q, overflow_q, rise;
  sync_edge_det u_det (.clk(clk), .rst_n(rst_n), .d_async(osc_in), .rise(rise));
  // tmr_q counts down the remaining cycles of SETTLE or MEASURE; win_q holds window-1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      tmr_q      <= '0;
      count_q    <= '0;
      osc_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (start) begin
            busy_q <= 1'b1;
            win_q  <= window - 1'b1;
            if (window == '0) begin
              state_q    <= S_DONE;
              valid_q    <= 1'b1;
              count_q    <= '0;
              overflow_q <= 1'b0;
            end else begin
              state_q  <= S_SETTLE;
              tmr_q    <= SET_LD;
              osc_en_q <= 1'b1;
            end
          end
        S_SETTLE:
          if (tmr_q == '0) begin
            state_q    <= S_MEASURE;
            tmr_q      <= win_q;
            count_q    <= '0;
            overflow_q <= 1'b0;
          end else tmr_q <= tmr_q - 1'b1;
        S_MEASURE: begin
          if (rise) begin
            if (&count_q) overflow_q <= 1'b1;
            else          count_q    <= count_q + 1'b1;
          end
          if (tmr_q == '0) begin
            state_q  <= S_DONE;
            osc_en_q <= 1'b0;
            valid_q  <= 1'b1;
          end else tmr_q <= tmr_q - 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  assign osc_en   = osc_en_q;
  assign busy     = busy_q;
  assign count    = count_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_osc_freq_meter.sv
// tb_osc_freq_meter: directed tests of the frequency meter; a CNT_W=4 copy shares all stimulus
module tb_osc_freq_meter;
  logic        clk = 0, rst_n = 0, start = 0, osc_in = 0;
  logic [15:0] window = '0;
  logic        osc_en, busy, valid, overflow, osc_en4, busy4, valid4, overflow4;
  logic [15:0] count;
  logic [3:0]  count4;
  int cyc = 0, osc_per = 0, ph = 0;
  int n_chk = 0, n_fail = 0;
  int t0, vcyc, nvalid, en_cnt, en_first, en_last, rc, ro, rc4, ro4;

  osc_freq_meter dut (.clk(clk), .rst_n(rst_n), .start(start), .window(window), .osc_in(osc_in),
    .osc_en(osc_en), .busy(busy), .count(count), .valid(valid), .overflow(overflow));
  osc_freq_meter #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start), .window(window),
    .osc_in(osc_in), .osc_en(osc_en4), .busy(busy4), .count(count4), .valid(valid4),
    .overflow(overflow4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (osc_per == 0) begin
      osc_in <= 1'b0;
      ph     <= 0;
    end else begin
      ph     <= (ph + 1 >= osc_per) ? 0 : ph + 1;
      osc_in <= (ph < osc_per / 2);
    end

  task automatic run(input logic [15:0] win, input int per, input bit spam);
    osc_per = per;
    @(negedge clk);
    window = win; start = 1; t0 = cyc;
    vcyc = -1; nvalid = 0; en_cnt = 0; en_first = -1; en_last = -1;
    for (int i = 0; i < int'(win) + 48; i++) begin
      @(negedge clk);
      start = spam && vcyc < 0;
      if (spam) window = 16'd3;
      if (osc_en) begin
        en_cnt++;
        if (en_first < 0) en_first = cyc;
        en_last = cyc;
      end
      if (valid) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc = cyc; rc = int'(count); ro = int'(overflow); rc4 = int'(count4); ro4 = int'(overflow4);
        end
      end
    end
    start = 0;
  endtask

  task automatic test_reset;
    osc_per = 4; rst_n = 0;
    repeat (6) @(negedge clk);
    n_chk++;
    if ({osc_en, busy, valid, overflow, count} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %b/%b/%b/%b/%0d want all 0", osc_en, busy, valid, overflow, count);
    end
    n_chk++;
    if ({dut.u_det.s1_q, dut.u_det.s2_q, dut.u_det.h_q} !== 3'b000) begin
      n_fail++; $display("FAIL reset_sync got %b want 000", {dut.u_det.s1_q, dut.u_det.s2_q, dut.u_det.h_q});
    end
    rst_n = 1; nvalid = 0;
    repeat (20) begin @(negedge clk); if (valid || busy || osc_en) nvalid++; end
    n_chk++;
    if (nvalid != 0) begin n_fail++; $display("FAIL idle_quiet got %0d active cycles want 0", nvalid); end
  endtask

  task automatic test_nominal;
    run(16'd1000, 10, 0);
    n_chk++;
    if (vcyc != t0 + 1009) begin n_fail++; $display("FAIL nom_latency got %0d want %0d", vcyc - t0, 1009); end
    n_chk++;
    if (rc < 99 || rc > 101 || ro != 0) begin n_fail++; $display("FAIL nom_count got %0d ovf %0d want 99..101 ovf 0", rc, ro); end
    n_chk++;
    if (nvalid != 1 || en_cnt != 1008 || en_first != t0 + 1) begin
      n_fail++; $display("FAIL nom_en got valids %0d en %0d first %0d want 1 1008 1", nvalid, en_cnt, en_first - t0);
    end
  endtask

  task automatic test_stuck;
    run(16'd500, 0, 0);
    n_chk++;
    if (vcyc != t0 + 509 || rc != 0 || ro != 0) begin
      n_fail++; $display("FAIL stuck got lat %0d count %0d ovf %0d want 509 0 0", vcyc - t0, rc, ro);
    end
    n_chk++;
    if (en_cnt != 508 || en_first != t0 + 1 || en_last != t0 + 508) begin
      n_fail++; $display("FAIL stuck_en got %0d %0d..%0d want 508 1..508", en_cnt, en_first - t0, en_last - t0);
    end
  endtask

  task automatic test_saturation;
    run(16'd100, 4, 0);
    n_chk++;
    if (rc4 != 15 || ro4 != 1) begin n_fail++; $display("FAIL sat4 got %0d ovf %0d want 15 1", rc4, ro4); end
    n_chk++;
    if (rc < 24 || rc > 26 || ro != 0) begin n_fail++; $display("FAIL sat16 got %0d ovf %0d want 24..26 0", rc, ro); end
    repeat (5) @(negedge clk);
    n_chk++;
    if (count4 !== 4'd15 || overflow4 !== 1'b1) begin
      n_fail++; $display("FAIL sat_hold got %0d ovf %b want 15 1", count4, overflow4);
    end
  endtask

  task automatic test_window_zero;
    run(16'd0, 4, 0);
    n_chk++;
    if (vcyc != t0 + 1 || nvalid != 1) begin n_fail++; $display("FAIL w0_latency got %0d valids %0d want 1 1", vcyc - t0, nvalid); end
    n_chk++;
    if (rc != 0 || ro != 0 || en_cnt != 0) begin
      n_fail++; $display("FAIL w0_state got count %0d ovf %0d en %0d want 0 0 0", rc, ro, en_cnt);
    end
  endtask

  task automatic test_back_to_back;
    run(16'd50, 10, 1);
    n_chk++;
    if (nvalid != 1 || vcyc != t0 + 59) begin
      n_fail++; $display("FAIL busy_start got valids %0d lat %0d want 1 59", nvalid, vcyc - t0);
    end
    n_chk++;
    if (rc < 4 || rc > 6) begin n_fail++; $display("FAIL busy_count got %0d want 4..6", rc); end
  endtask

  task automatic test_reset_mid;
    osc_per = 10;
    @(negedge clk);
    window = 16'd1000; start = 1; t0 = cyc;
    @(negedge clk);
    start = 0;
    while (cyc < t0 + 309) @(negedge clk);
    n_chk++;
    if (!osc_en || !busy || count == 0) begin
      n_fail++; $display("FAIL mid_pre got en %b busy %b count %0d want 1 1 >0", osc_en, busy, count);
    end
    rst_n = 0;
    #1;
    n_chk++;
    if ({osc_en, busy, valid, count} !== '0) begin
      n_fail++; $display("FAIL mid_reset got %b/%b/%b/%0d want all 0", osc_en, busy, valid, count);
    end
    nvalid = 0;
    repeat (5) begin @(negedge clk); if (valid) nvalid++; end
    rst_n = 1;
    repeat (1000) begin @(negedge clk); if (valid) nvalid++; end
    n_chk++;
    if (nvalid != 0) begin n_fail++; $display("FAIL mid_novalid got %0d want 0", nvalid); end
    run(16'd100, 10, 0);
    n_chk++;
    if (vcyc != t0 + 109 || rc < 9 || rc > 11 || nvalid != 1) begin
      n_fail++; $display("FAIL restart got lat %0d count %0d valids %0d want 109 9..11 1", vcyc - t0, rc, nvalid);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_stuck;
    test_saturation;
    test_window_zero;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
